// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding and column slicing helpers
// Purpose: common typedefs for the MixColumns engine plus helpers that read and
// write one 32-bit column of a 128-bit state in FIPS-197 byte order
// (column c occupies [127-32c -: 32], row 0 is the most significant byte).
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mc_state_t;

  // Reduction constant for x^8 = x^4 + x^3 + x + 1.
  localparam byte_t GF_POLY = 8'h1b;

  function automatic word_t col_get(state_t s, logic [1:0] c);
    word_t w;
    unique case (c)
      2'd0: w = s[127:96];
      2'd1: w = s[95:64];
      2'd2: w = s[63:32];
      2'd3: w = s[31:0];
    endcase
    return w;
  endfunction

  function automatic state_t col_put(state_t s, logic [1:0] c, word_t w);
    state_t r;
    r = s;
    unique case (c)
      2'd0: r[127:96] = w;
      2'd1: r[95:64]  = w;
      2'd2: r[63:32]  = w;
      2'd3: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mixcolumns_seq_if.sv
// rtl/mixcolumns_seq_if.sv - start/done request bus of the MixColumns engine
// Purpose: groups the request (start, bypass, state_in) and the response
// (busy, done, state_out) of mixcolumns_seq.
//   master: round controller side, drives the request, observes the response
//   slave : engine side, observes the request, drives the response
interface mixcolumns_seq_if;
  import aes_pkg::*;

  logic   start;
  logic   bypass;
  state_t state_in;
  logic   busy;
  logic   done;
  state_t state_out;

  modport master (
    output start, bypass, state_in,
    input  busy, done, state_out
  );

  modport slave (
    input  start, bypass, state_in,
    output busy, done, state_out
  );

endinterface

// File: rtl/galoismult.sv
// rtl/galoismult.sv - multiply one GF(2^8) byte by x (xtime)
// Purpose: combinational xtime.
//   a_i  : input byte
//   xt_o : a_i * x reduced modulo the AES polynomial
module galoismult
  import aes_pkg::*;
(
  input  byte_t a_i,
  output byte_t xt_o
);

  assign xt_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? GF_POLY : 8'h00);

endmodule

// File: rtl/mixcolumn_col.sv
// rtl/mixcolumn_col.sv - combinational MixColumns of one 32-bit column
// Purpose: b_r = 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}, indices mod 4, with
// 3*a expanded as xt(a) ^ a so only four xtime units are needed.
//   col_i : input column, row 0 in [31:24]
//   col_o : transformed column, same layout
module mixcolumn_col
  import aes_pkg::*;
(
  input  word_t col_i,
  output word_t col_o
);

  byte_t a [4];
  byte_t x [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_i[31-8*r -: 8];

    galoismult u_xt (
      .a_i  (a[r]),
      .xt_o (x[r])
    );

    assign col_o[31-8*r -: 8] = x[r] ^ x[(r+1)%4] ^ a[(r+1)%4]
                              ^ a[(r+2)%4] ^ a[(r+3)%4];
  end

endmodule

// File: rtl/mixcolumns_seq.sv
// rtl/mixcolumns_seq.sv - sequential MixColumns engine with start/done handshake
// Purpose: applies MixColumns to a 128-bit state COLS_PER_CYCLE columns per
// clock using shared column units; bypass passes the state through unchanged
// (final round).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of mixcolumns_seq_if (start/bypass/state_in in,
//           busy/done/state_out out)
// COLS_PER_CYCLE must be 1, 2 or 4.
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic             clk,
  input  logic             reset,
  mixcolumns_seq_if.slave  bus
);

  // Column index advance per active cycle; for 4 columns it wraps to 0, which
  // is exactly the single-pass case.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  // Starting column of the last group, i.e. the group that writes column 3.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  mc_state_t  state_q;
  state_t     work_q;
  state_t     work_d;
  state_t     out_q;
  logic [1:0] col_q;
  logic       busy_q;
  logic       done_q;

  word_t unit_in  [COLS_PER_CYCLE];
  word_t unit_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    assign unit_in[g] = col_get(work_q, col_q + 2'(g));

    mixcolumn_col u_col (
      .col_i (unit_in[g]),
      .col_o (unit_out[g])
    );
  end

  // Working register with the current column group replaced by its result.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_d = col_put(work_d, col_q + 2'(g), unit_out[g]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      col_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q <= bus.state_in;
            col_q  <= 2'd0;
            busy_q <= 1'b1;
            if (bus.bypass) begin
              // Output is taken straight from the input so done can rise
              // on the accepting edge.
              state_q <= DONE;
              done_q  <= 1'b1;
              out_q   <= bus.state_in;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          work_q <= work_d;
          col_q  <= col_q + STEP;
          if (col_q == LAST_COL) begin
            // work_d already holds column 3, publish it with the done pulse.
            state_q <= DONE;
            done_q  <= 1'b1;
            out_q   <= work_d;
            col_q   <= 2'd0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          col_q   <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          col_q   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = out_q;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// tb/tb_mixcolumns_seq.sv - self-checking bench for mixcolumns_seq (1, 2, 4 columns per cycle)
module tb_mixcolumns_seq;
  import aes_pkg::*;

  localparam state_t FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam state_t FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam state_t ID_IN    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam state_t ID_OUT   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  typedef struct {
    state_t din;
    bit     byp;
    state_t exp;
    bit     inject;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   bypass = 1'b0;
  state_t state_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mixcolumns_seq_if if1 ();
  mixcolumns_seq_if if2 ();
  mixcolumns_seq_if if4 ();

  assign if1.start = start;  assign if1.bypass = bypass;  assign if1.state_in = state_in;
  assign if2.start = start;  assign if2.bypass = bypass;  assign if2.state_in = state_in;
  assign if4.start = start;  assign if4.bypass = bypass;  assign if4.state_in = state_in;

  mixcolumns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  mixcolumns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  mixcolumns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  logic   done_v [3];
  logic   busy_v [3];
  state_t out_v  [3];

  assign done_v[0] = if1.done;  assign busy_v[0] = if1.busy;  assign out_v[0] = if1.state_out;
  assign done_v[1] = if2.done;  assign busy_v[1] = if2.busy;  assign out_v[1] = if2.state_out;
  assign done_v[2] = if4.done;  assign busy_v[2] = if4.busy;  assign out_v[2] = if4.state_out;

  function automatic int cpc(int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // Cycle (1 = cycle right after the start edge) in which done is high.
  function automatic int lat(int d, bit byp);
    if (byp) return 1;
    return 4 / cpc(d) + 1;
  endfunction

  // Generic GF(2^8) multiply, shift-and-add.
  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    logic  hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Matrix form: row r of each column dotted with circulant [2 3 1 1].
  function automatic state_t ref_mc(state_t s, bit byp);
    byte_t  a [4][4];
    byte_t  coef [4];
    state_t r;
    byte_t  acc;
    if (byp) return s;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        a[c][k] = s[127-32*c-8*k -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(a[c][(k+j)%4], coef[j]);
        r[127-32*c-8*k -: 8] = acc;
      end
    return r;
  endfunction

  function automatic state_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s cpc%0d busy", tag, cpc(d)), 128'(busy_v[d]), 128'd0);
      check($sformatf("%s cpc%0d done", tag, cpc(d)), 128'(done_v[d]), 128'd0);
      check($sformatf("%s cpc%0d state_out", tag, cpc(d)), out_v[d], 128'd0);
    end
  endtask

  // One operation on all three engines; optionally pulses start with other
  // data while they are busy.
  task automatic run_op(input string name, input state_t din, input bit byp,
                        input state_t exp, input bit inject);
    int     first  [3];
    int     pulses [3];
    bit     busy_bad [3];
    bit     stable_bad [3];
    state_t prev [3];
    state_t at_done [3];
    int     l;
    for (int d = 0; d < 3; d++) begin
      first[d] = 0; pulses[d] = 0; busy_bad[d] = 0; stable_bad[d] = 0;
      prev[d] = out_v[d]; at_done[d] = '0;
    end
    @(negedge clk);
    start = 1'b1; bypass = byp; state_in = din;
    @(posedge clk);
    #1;
    start = 1'b0; bypass = 1'($urandom); state_in = rand128();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        l = lat(d, byp);
        if (done_v[d] === 1'b1) begin
          pulses[d]++;
          if (first[d] == 0) begin
            first[d] = k;
            at_done[d] = out_v[d];
          end
        end
        if (busy_v[d] !== (k <= l)) busy_bad[d] = 1'b1;
        if (k < l && out_v[d] !== prev[d]) stable_bad[d] = 1'b1;
        if (k > l && out_v[d] !== at_done[d]) stable_bad[d] = 1'b1;
      end
      if (inject && k == 2) begin
        start = 1'b1; state_in = rand128();
      end
      if (inject && k == 3) start = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s cpc%0d latency", name, cpc(d)), 128'(first[d]), 128'(lat(d, byp)));
      check($sformatf("%s cpc%0d done_pulses", name, cpc(d)), 128'(pulses[d]), 128'd1);
      check($sformatf("%s cpc%0d state_out", name, cpc(d)), out_v[d], exp);
      check($sformatf("%s cpc%0d busy_window", name, cpc(d)), 128'(busy_bad[d]), 128'd0);
      check($sformatf("%s cpc%0d out_stable", name, cpc(d)), 128'(stable_bad[d]), 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl [4];

  initial begin
    int     last [3];
    int     cnt  [3];
    bit     gap_bad [3];
    bit     seen_done;
    state_t din;
    bit     byp;
    bit     inj;

    tbl[0] = '{din: FIPS_IN,  byp: 1'b0, exp: FIPS_OUT, inject: 1'b0};
    tbl[1] = '{din: ID_IN,    byp: 1'b0, exp: ID_OUT,   inject: 1'b0};
    tbl[2] = '{din: FIPS_IN,  byp: 1'b1, exp: FIPS_IN,  inject: 1'b0};
    tbl[3] = '{din: FIPS_IN,  byp: 1'b0, exp: FIPS_OUT, inject: 1'b1};

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].din, tbl[i].byp, tbl[i].exp, tbl[i].inject);

    // Reset after two active cycles of the one-column engine.
    @(negedge clk);
    start = 1'b1; bypass = 1'b0; state_in = FIPS_IN;
    @(posedge clk);
    #1 start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) seen_done = 1'b1;
    end
    reset = 1'b1;
    #1 check_zero_outputs("midrun_reset");
    repeat (3) @(negedge clk);
    if (done_v[0] === 1'b1) seen_done = 1'b1;
    check("midrun_reset cpc1 no_done", 128'(seen_done), 128'd0);
    reset = 1'b0;
    run_op("after_reset", FIPS_IN, 1'b0, FIPS_OUT, 1'b0);

    // Start held high: one done every latency+1 cycles.
    for (int d = 0; d < 3; d++) begin
      last[d] = 0; cnt[d] = 0; gap_bad[d] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; bypass = 1'b0; state_in = FIPS_IN;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d] === 1'b1) begin
          if (cnt[d] == 0 && k != lat(d, 1'b0)) gap_bad[d] = 1'b1;
          if (cnt[d] != 0 && k - last[d] != lat(d, 1'b0) + 1) gap_bad[d] = 1'b1;
          if (out_v[d] !== FIPS_OUT) gap_bad[d] = 1'b1;
          last[d] = k;
          cnt[d]++;
        end
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("b2b cpc%0d cadence", cpc(d)), 128'(gap_bad[d]), 128'd0);
      check($sformatf("b2b cpc%0d done_count", cpc(d)), 128'(cnt[d]),
            128'((24 - lat(d, 1'b0)) / (lat(d, 1'b0) + 1) + 1));
    end

    // Randomized operations against the matrix model.
    for (int i = 0; i < 16; i++) begin
      din = rand128();
      byp = ($urandom_range(0, 3) == 0);
      inj = !byp && ($urandom_range(0, 1) == 1);
      run_op($sformatf("rand%0d", i), din, byp, ref_mc(din, byp), inj);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixcolumns_seq.md
Name: mixcolumns_seq

Overview:
Sequential MixColumns engine for the AES core. It takes a 128-bit state, applies MixColumns column-by-column over several cycles using a small number of shared column units, and signals completion with a start/done handshake. Each column unit uses galoismult (xtime) instances. The round controller drives it once per round. It bypasses the transform on the final round.

Parameters:
COLS_PER_CYCLE, 1, columns processed per active cycle; legal values 1, 2, 4; active cycles = 4/COLS_PER_CYCLE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
bypass  input  1  sampled with start; 1 = final round, output equals input
state_in  input  128  AES state, FIPS-197 order; column c = [127-32c -: 32], row r within column = [127-32c-8r -: 8]
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; state_out valid from this cycle
state_out  output  128  result; holds until the next accepted start or reset

Behaviour:
- Reset (async, immediate): FSM=IDLE, working register=0, state_out=0, busy=0, done=0, column index=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge T0, latch state_in into the working register, latch bypass, and set col=0.
  - Go to RUN if bypass=0; go to DONE if bypass=1.
  - start=0: stay in IDLE.
- RUN: each edge replaces columns col..col+COLS_PER_CYCLE-1 of the working register with their MixColumns result.
  - col advances by COLS_PER_CYCLE.
  - After the edge that writes column 3, go to DONE.
  - Column index wraps to 0 when returning to IDLE.
- DONE: done=1 for exactly one cycle, state_out = working register; next edge goes to IDLE.
- Latency from the start edge T0 to done high:
  - COLS_PER_CYCLE=1: 5 cycles (4 RUN + 1).
  - COLS_PER_CYCLE=2: 3 cycles.
  - COLS_PER_CYCLE=4: 2 cycles.
  - bypass=1: 1 cycle.
- state_out updates only on entry to DONE. It is stable while busy and between operations.
- start asserted while busy is ignored; there is no queueing. start high on the same edge that leaves DONE is also ignored. A start held continuously is re-accepted in the following IDLE cycle.
- state_in and bypass are sampled only at the accepting edge. Later changes have no effect.
- Column math, all in GF(2^8): b_r = xt(a_r) ^ xt(a_{r+1}) ^ a_{r+1} ^ a_{r+2} ^ a_{r+3}, indices mod 4.
  - xt = galoismult: {a[6:0],0} ^ (a[7] ? 8'h1b : 0).
  - XOR only; no carries or widening.
- Reset mid-operation aborts immediately:
  - outputs return to their reset values;
  - no done pulse is produced for the aborted operation;
  - the next start after reset release behaves normally.

Decomposition:
- aes_pkg:
  - typedefs byte_t (logic [7:0]), word_t ([31:0]), state_t ([127:0]);
  - enum mc_state_t {IDLE, RUN, DONE};
  - constant GF_POLY = 8'h1b;
  - col_get/col_put functions for column slicing.
- Sub-module mixcolumn_col: one 32-bit column, 4 galoismult instances plus the XOR network, purely combinational.
- mixcolumns_seq instantiates COLS_PER_CYCLE copies via generate and holds the FSM, column counter and working register.

Test Plan:
1. Reset high mid-RUN (after 2 active cycles) -> busy=0, done=0, state_out=0 immediately (async); next start completes with the correct result.
2. FIPS-197 round-1 vector, COLS_PER_CYCLE=1:
   - stimulus: start with state_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5;
   - required: done exactly 5 cycles after the start edge, state_out = 046681e5_e0cb199a_48f8d37a_2806264c;
   - busy high for those 5 cycles.
3. Column identity vectors:
   - stimulus: db135345_f20a225c_01010101_c6c6c6c6;
   - required: state_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 (exercises the a[7] reduction path).
4. bypass=1 with the vector from scenario 2 -> done after 1 cycle, state_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5.
5. start pulsed during RUN with a different state_in -> ignored; result and timing are identical to scenario 2, and exactly one done pulse occurs.
6. Repeat scenario 2 with COLS_PER_CYCLE=2 and 4 -> same state_out, done latency 3 and 2 cycles; back-to-back starts held high yield a done every latency+1 cycles.
